// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: issues the dcache request from EX/MEM, stalls until dhit, loads MEM/WB.
// Optional load-linked/store-conditional link register enabled by `define LLSC_EN.
module mem_stage_ctrl #(
    parameter int unsigned AW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ex_valid,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    input  logic          ex_ll,
    input  logic          ex_sc,
    input  logic          ex_regw,
    input  logic [RW-1:0] ex_wsel,
    input  logic [AW-1:0] ex_aluout,
    input  logic [AW-1:0] ex_store,
    input  logic          ex_halt,
    input  logic          flush,
    input  logic          dhit,
    input  logic [AW-1:0] dmemload,
    input  logic          snoop_inv,
    input  logic [AW-1:0] snoop_addr,
    output logic          dREN,
    output logic          dWEN,
    output logic [AW-1:0] dmemaddr,
    output logic [AW-1:0] dmemstore,
    output logic          mem_stall,
    output logic          wb_valid,
    output logic          wb_regw,
    output logic [RW-1:0] wb_wsel,
    output logic [AW-1:0] wb_wdat,
    output logic          wb_halt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALTED} state_t;

    state_t        state, state_nx;
    logic          pend_flush;
    logic          is_read, is_write, sc_pass;
    logic          issue, load_wb, bubble, live_halt;
    logic [AW-1:0] wdat_c;

    assign is_read   = ex_memread | ex_ll;
    assign is_write  = ex_memwrite | ex_sc;
    assign dmemaddr  = ex_aluout;
    assign dmemstore = ex_store;
    assign bubble    = !ex_valid || flush || pend_flush;
    assign live_halt = ex_halt && !bubble;

`ifdef LLSC_EN
    logic          link_valid;
    logic [AW-1:0] link_addr;
    logic          store_done, ll_done;

    // An SC that reached WAIT was already validated when it issued.
    assign sc_pass    = (state == S_WAIT) || (link_valid && (link_addr == ex_aluout));
    assign store_done = load_wb && ex_valid && (ex_memwrite || (ex_sc && sc_pass));
    assign ll_done    = load_wb && ex_valid && ex_ll;

    // Snoop and own stores clear the link; a snoop to the LL address blocks the new link.
    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (snoop_inv && (snoop_addr == link_addr))
                link_valid <= 1'b0;
            if (store_done && (ex_aluout == link_addr))
                link_valid <= 1'b0;
            if (ll_done && !(snoop_inv && (snoop_addr == ex_aluout))) begin
                link_valid <= 1'b1;
                link_addr  <= ex_aluout;
            end
        end
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{snoop_inv, snoop_addr};
    assign sc_pass      = 1'b1;
`endif

    assign wdat_c = is_read ? dmemload : (ex_sc ? AW'(sc_pass) : ex_aluout);

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (issue && !dhit)          state_nx = S_WAIT;
                else if (load_wb && live_halt) state_nx = S_HALTED;
            end
            S_WAIT: begin
                if (dhit) state_nx = live_halt ? S_HALTED : S_IDLE;
            end
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Request, stall and MEM/WB load strobe; reset drops the request immediately.
    always_comb begin
        issue     = 1'b0;
        load_wb   = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        mem_stall = 1'b0;
        if (!RST) begin
            case (state)
                S_IDLE: issue = ex_valid && (is_read || ex_memwrite || (ex_sc && sc_pass));
                S_WAIT: issue = ex_valid && (is_read || is_write);
                default: issue = 1'b0;
            endcase
            if (issue) begin
                dREN      = is_read;
                dWEN      = is_write;
                load_wb   = dhit;
                mem_stall = !dhit;
            end else begin
                load_wb = (state == S_IDLE);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_valid   <= 1'b0;
            wb_regw    <= 1'b0;
            wb_wsel    <= '0;
            wb_wdat    <= '0;
            wb_halt    <= 1'b0;
            pend_flush <= 1'b0;
        end else if (load_wb) begin
            wb_valid   <= !bubble && !ex_halt;
            wb_regw    <= !bubble && !ex_halt && ex_regw;
            wb_wsel    <= ex_wsel;
            wb_wdat    <= wdat_c;
            wb_halt    <= wb_halt || live_halt;
            pend_flush <= 1'b0;
        end else if (flush && (state != S_HALTED)) begin
            pend_flush <= 1'b1;
        end
    end

endmodule
